// File: rtl/apb_regfile_slave.sv
// rtl/apb_regfile_slave.sv - parametrised APB register file with wait states, byte strobes and error response
module apb_regfile_slave #(
    parameter int                  ADDR_WIDTH  = 8,
    parameter int                  DATA_WIDTH  = 32,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_STATES = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
    output logic [NUM_REGS-1:0]            reg_wr_stb
);

    localparam int         IDX_W     = ADDR_WIDTH - 2;
    localparam int         NB        = DATA_WIDTH / 8;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_wcnt;
    logic [3:0]            w_wcnt_nxt;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_wr_stb;

    logic [IDX_W-1:0]      w_idx;
    logic [NUM_REGS-1:0]   w_hit;
    logic                  w_in_range;
    logic                  w_ro;
    logic                  w_err;
    logic                  w_ready;
    logic                  w_complete;
    logic                  w_commit;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_unused_addr_lsbs;

    assign w_idx              = PADDR[ADDR_WIDTH-1:2];
    assign w_unused_addr_lsbs = ^PADDR[1:0];

    // One-hot word decode; an index past the last register hits nothing.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_hit[i] = (w_idx == IDX_W'(i));
        end
    end

    assign w_in_range = |w_hit;
    assign w_ro       = |(w_hit & RO_MASK);
    assign w_err      = !w_in_range || (PWRITE && w_ro);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        case (r_state)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_state_nxt = S_ACCESS;
                    w_wcnt_nxt  = WAIT_LOAD;
                end
            end
            S_ACCESS: begin
                if (!PSEL) begin
                    w_state_nxt = S_IDLE;
                end else if (r_wcnt != 4'd0) begin
                    w_wcnt_nxt = r_wcnt - 4'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_wcnt_nxt  = '0;
            end
        endcase
    end

    // A deselected bus in the last access cycle is an abort: no error, no data, no write.
    assign w_ready    = (r_state == S_ACCESS) && (r_wcnt == 4'd0);
    assign w_complete = w_ready && PSEL && PENABLE;
    assign w_commit   = w_complete && PWRITE && !w_err;

    always_comb begin
        w_rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_hit[i]) begin
                w_rd_word = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
            end
        end
    end

    assign PREADY  = w_ready;
    assign PSLVERR = w_complete && w_err;
    assign PRDATA  = (w_complete && !PWRITE) ? w_rd_word : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_hit[i] && !RO_MASK[i]) begin
                    for (int b = 0; b < NB; b++) begin
                        if (PSTRB[b]) begin
                            r_regs[i][8*b +: 8] <= PWDATA[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wr_stb <= '0;
        end else begin
            r_wr_stb <= w_commit ? (w_hit & ~RO_MASK) : '0;
        end
    end

    assign reg_wr_stb = r_wr_stb;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_q
            assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[gi] ? '0 : r_regs[gi];
        end
    endgenerate

endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb/tb_apb_regfile_slave.sv - randomized APB register file bench with transaction-level reference model
module tb_apb_regfile_slave;

    localparam int         AW = 8;
    localparam int         DW = 32;
    localparam int         NR = 8;
    localparam int         WS = 1;
    localparam logic [7:0] RO = 8'h80;

    logic             PCLK = 1'b0;
    logic             PRESETn;
    logic             PSEL;
    logic             PENABLE;
    logic             PWRITE;
    logic [AW-1:0]    PADDR;
    logic [DW-1:0]    PWDATA;
    logic [DW/8-1:0]  PSTRB;
    logic [DW-1:0]    PRDATA;
    logic             PREADY;
    logic             PSLVERR;
    logic [NR*DW-1:0] reg_q;
    logic [NR*DW-1:0] hw_status;
    logic [NR-1:0]    reg_wr_stb;

    apb_regfile_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .WAIT_STATES(WS),
        .RO_MASK    (RO)
    ) u_dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .reg_q     (reg_q),
        .hw_status (hw_status),
        .reg_wr_stb(reg_wr_stb)
    );

    always #5 PCLK = ~PCLK;

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_rdy = 0;
    bit          chk_en = 1'b0;
    logic [31:0] m_regs [NR];
    logic [31:0] m_next [NR];
    logic [NR-1:0] stb_pending;
    logic [NR-1:0] exp_stb;
    logic        exp_pready;
    logic        exp_pslverr;
    logic [31:0] exp_prdata;
    logic [31:0] last_prdata;
    logic        last_pslverr;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NR*DW-1:0] exp_regq();
        logic [NR*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) begin
            if (!RO[i]) v[i*DW +: DW] = m_regs[i];
        end
        return v;
    endfunction

    function automatic logic [31:0] rd_val(input int idx);
        if (RO[idx]) return hw_status[idx*DW +: DW];
        return m_regs[idx];
    endfunction

    always @(negedge PCLK) begin
        if (chk_en) begin
            chk("pready", PREADY, exp_pready);
            chk("pslverr", PSLVERR, exp_pslverr);
            chk("prdata", PRDATA, exp_prdata);
            chk("reg_wr_stb", reg_wr_stb, exp_stb);
            chk("reg_q", reg_q, exp_regq());
            if (PREADY) begin
                n_rdy++;
                last_prdata  = PRDATA;
                last_pslverr = PSLVERR;
            end
        end
    end

    task automatic step();
        @(posedge PCLK);
        #1;
        m_regs      = m_next;
        exp_stb     = stb_pending;
        stb_pending = '0;
        exp_pready  = 1'b0;
        exp_pslverr = 1'b0;
        exp_prdata  = '0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            PSEL    = 1'b0;
            PENABLE = 1'b0;
            PADDR   = 8'($urandom);
            PWRITE  = 1'($urandom);
            step();
        end
    endtask

    // One APB transfer; abort_at >= 0 drops PSEL in that wait cycle.
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int abort_at);
        int   idx;
        logic err;
        idx = int'(addr[7:2]);
        err = (idx >= NR) ? 1'b1 : (wr && RO[idx]);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        PSTRB   = strb;
        step();
        PENABLE = 1'b1;
        for (int w = 0; w < WS; w++) begin
            if (w == abort_at) begin
                PSEL    = 1'b0;
                PENABLE = 1'b0;
                step();
                return;
            end
            step();
        end
        exp_pready  = 1'b1;
        exp_pslverr = err;
        exp_prdata  = (!wr && !err) ? rd_val(idx) : 32'h0;
        if (wr && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) m_next[idx][8*b +: 8] = data[8*b +: 8];
            end
            stb_pending[idx] = 1'b1;
        end
        step();
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_next[i] = '0;
        end
        stb_pending = '0;
        exp_stb     = '0;
        exp_pready  = 1'b0;
        exp_pslverr = 1'b0;
        exp_prdata  = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int n_before;
        PRESETn = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        PSTRB   = '0;
        for (int i = 0; i < NR; i++) hw_status[i*DW +: DW] = $urandom;
        model_reset();
        last_prdata  = '0;
        last_pslverr = 1'b0;
        #2;
        PRESETn = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        chk("reset_regq", reg_q, 256'h0);
        chk("reset_pready", PREADY, 1'b0);
        PRESETn = 1'b1;
        idle(2);

        xfer(1'b1, 8'h08, 32'hDEADBEEF, 4'hF, -1);
        chk("wr_stb_reg2", reg_wr_stb, 8'h04);
        chk("wr_pslverr", last_pslverr, 1'b0);
        xfer(1'b0, 8'h08, 32'h0, 4'h0, -1);
        chk("rd_deadbeef", last_prdata, 32'hDEADBEEF);
        chk("rd_pslverr", last_pslverr, 1'b0);

        xfer(1'b1, 8'h04, 32'h11223344, 4'hF, -1);
        xfer(1'b1, 8'h05, 32'hAABBCCDD, 4'b0101, -1);
        xfer(1'b0, 8'h04, 32'h0, 4'h0, -1);
        chk("byte_strobe", last_prdata, 32'h11BB33DD);

        xfer(1'b1, 8'h20, 32'h5, 4'hF, -1);
        chk("oor_wr_err", last_pslverr, 1'b1);
        chk("oor_wr_stb", reg_wr_stb, 8'h00);
        xfer(1'b0, 8'h20, 32'h0, 4'h0, -1);
        chk("oor_rd_data", last_prdata, 32'h0);
        chk("oor_rd_err", last_pslverr, 1'b1);

        hw_status[7*DW +: DW] = 32'hCAFEF00D;
        xfer(1'b0, 8'h1C, 32'h0, 4'h0, -1);
        chk("ro_rd_data", last_prdata, 32'hCAFEF00D);
        chk("ro_rd_err", last_pslverr, 1'b0);
        xfer(1'b1, 8'h1C, 32'h01020304, 4'hF, -1);
        chk("ro_wr_err", last_pslverr, 1'b1);
        chk("ro_wr_stb", reg_wr_stb, 8'h00);

        idle(1);
        n_before = n_rdy;
        xfer(1'b1, 8'h00, 32'hA0A0A0A0, 4'hF, -1);
        xfer(1'b1, 8'h0C, 32'hB1B1B1B1, 4'hF, -1);
        xfer(1'b1, 8'h10, 32'hC2C2C2C2, 4'hF, -1);
        chk("b2b_ready_count", n_rdy - n_before, 3);
        xfer(1'b0, 8'h0C, 32'h0, 4'h0, -1);
        chk("b2b_rd", last_prdata, 32'hB1B1B1B1);

        xfer(1'b1, 8'h18, 32'h12345678, 4'hF, 0);
        chk("abort_stb", reg_wr_stb, 8'h00);
        xfer(1'b0, 8'h18, 32'h0, 4'h0, -1);
        chk("abort_no_write", last_prdata, 32'h0);
        xfer(1'b1, 8'h18, 32'h87654321, 4'hF, -1);
        xfer(1'b0, 8'h18, 32'h0, 4'h0, -1);
        chk("after_abort_rd", last_prdata, 32'h87654321);

        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = 8'h14;
        PWDATA  = 32'h55AA55AA;
        PSTRB   = 4'hF;
        step();
        PENABLE = 1'b1;
        PRESETn = 1'b0;
        model_reset();
        step();
        chk("midrst_regq", reg_q, 256'h0);
        chk("midrst_pready", PREADY, 1'b0);
        step();
        PRESETn = 1'b1;
        idle(1);
        xfer(1'b1, 8'h14, 32'h0BADF00D, 4'hF, -1);
        xfer(1'b0, 8'h14, 32'h0, 4'h0, -1);
        chk("post_rst_rd", last_prdata, 32'h0BADF00D);

        for (int n = 0; n < 400; n++) begin
            logic [7:0] addr;
            int         ab;
            if ($urandom_range(0, 9) == 0) begin
                for (int i = 0; i < NR; i++) hw_status[i*DW +: DW] = $urandom;
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            addr = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, NR*4-1));
            ab   = (WS > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(0, WS-1) : -1;
            xfer(1'($urandom), addr, $urandom, 4'($urandom), ab);
        end
        idle(2);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
